// File: rtl/acq_capture_pkg.sv
// Shared definitions for the acquisition capture hub: register map,
// CTRL/STATUS bit positions and the run-control state encoding.
// No logic; imported by acq_capture_hub and acq_fifo.
package acq_capture_pkg;

  // Register word addresses
  localparam logic [3:0] ADDR_CTRL     = 4'd0;
  localparam logic [3:0] ADDR_STATUS   = 4'd1;
  localparam logic [3:0] ADDR_DIVISOR  = 4'd2;
  localparam logic [3:0] ADDR_LIMIT    = 4'd3;
  localparam logic [3:0] ADDR_CH_SEL   = 4'd4;
  localparam logic [3:0] ADDR_LEVEL    = 4'd5;
  localparam logic [3:0] ADDR_DATA_LO  = 4'd6;
  localparam logic [3:0] ADDR_DATA_HI  = 4'd7;
  localparam logic [3:0] ADDR_TSTAMP   = 4'd8;

  // CTRL bits: start/abort/soft_rst are write-1 pulses, irq_en is R/W
  localparam int CTRL_START    = 0;
  localparam int CTRL_ABORT    = 1;
  localparam int CTRL_SOFT_RST = 2;
  localparam int CTRL_IRQ_EN   = 3;

  // STATUS field positions
  localparam int STAT_STATE_LSB = 0;
  localparam int STAT_OVF_LSB   = 8;
  localparam int STAT_EMPTY_LSB = 16;

  localparam int TS_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/acq_fifo.sv
// Single-clock FIFO with synchronous flush, level output and registered pop data.
// Latency: pushed word is poppable the next cycle; pop_data valid the cycle after pop.
// Backpressure: push while full is dropped unless a pop happens in the same cycle.
// Ports: clk, rst_n, flush, push/push_data, pop/pop_data, level, empty, full.
module acq_fifo
  import acq_capture_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 256
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       empty,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign level   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts the push.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pop_data <= '0;
    end else begin
      // Popping an empty FIFO returns zero and leaves the pointers alone.
      if (pop) begin
        pop_data <= do_pop ? mem[rd_ptr[AW-1:0]] : '0;
      end
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
        if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/acq_capture_hub.sv
// Run control, per-channel result FIFOs and 32-bit register slave between datapath and host.
// Latency: CSR writes act next cycle; csr_readdata valid one cycle after csr_read.
// Backpressure: none on ch_valid; samples arriving at a full FIFO are dropped and flagged.
// Ports: clk/reset_n; ch_data/ch_valid/calc_done from datapath; enable, ce_strobe,
// soft_reset, irq to datapath/host; csr_addr/csr_write/csr_writedata/csr_read/csr_readdata.
// Option: define ACQ_TIMESTAMP_EN to store a 32-bit cycle stamp with every FIFO entry.
module acq_capture_hub
  import acq_capture_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int DATA_W    = 64,
  parameter int DEPTH     = 256,
  parameter int RST_PULSE = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic [NUM_CH-1:0]        ch_valid,
  input  logic                     calc_done,
  output logic                     enable,
  output logic                     ce_strobe,
  output logic                     soft_reset,
  output logic                     irq,
  input  logic [3:0]               csr_addr,
  input  logic                     csr_write,
  input  logic [31:0]              csr_writedata,
  input  logic                     csr_read,
  output logic [31:0]              csr_readdata
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SRW = $clog2(RST_PULSE + 1);
`ifdef ACQ_TIMESTAMP_EN
  localparam int EW  = DATA_W + TS_W;
`else
  localparam int EW  = DATA_W;
`endif

  state_t            state;
  state_t            state_nxt;
  logic              run_entry;
  logic              limit_hit;

  logic              irq_en;
  logic [31:0]       divisor;
  logic [31:0]       sample_limit;
  logic [31:0]       ch_sel;
  logic [CW-1:0]     sel_ch;

  logic              wr_ctrl;
  logic              start_req;
  logic              abort_req;
  logic              sr_req;
  logic              rd_data_lo;

  logic [NUM_CH-1:0] cap;
  logic [NUM_CH-1:0] pop;
  logic [NUM_CH-1:0] ovf;
  logic [NUM_CH-1:0] fifo_empty;
  logic [NUM_CH-1:0] fifo_full;
  logic [31:0]       count      [NUM_CH];
  logic [EW-1:0]     fifo_in    [NUM_CH];
  logic [EW-1:0]     fifo_out   [NUM_CH];
  logic [AW:0]       fifo_level [NUM_CH];
  logic              fifo_flush;

  logic [31:0]       div_cnt;
  logic [31:0]       div_act;
  logic [31:0]       div_term;
  logic [SRW-1:0]    sr_cnt;

  logic [CW-1:0]     pop_ch;
  logic              fifo_rd_q;
  logic [31:0]       rd_q;
  logic [31:0]       rd_mux;
  logic [31:0]       status_w;
  logic [63:0]       pop_word;

  assign wr_ctrl    = csr_write && (csr_addr == ADDR_CTRL);
  assign start_req  = wr_ctrl && csr_writedata[CTRL_START];
  assign abort_req  = wr_ctrl && csr_writedata[CTRL_ABORT];
  assign sr_req     = wr_ctrl && csr_writedata[CTRL_SOFT_RST];
  assign rd_data_lo = csr_read && (csr_addr == ADDR_DATA_LO);
  assign sel_ch     = (ch_sel < 32'(NUM_CH)) ? ch_sel[CW-1:0] : '0;

  // ---------------- run-control FSM ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    run_entry = 1'b0;
    enable    = (state == ST_RUN);
    irq       = (state == ST_DONE) && irq_en;
    // Abort beats start; start is ignored while already running.
    if (abort_req) begin
      state_nxt = ST_IDLE;
    end else if (start_req && (state != ST_RUN)) begin
      state_nxt = ST_RUN;
      run_entry = 1'b1;
    end else if ((state == ST_RUN) && (calc_done || limit_hit)) begin
      state_nxt = ST_DONE;
    end
  end

  // Limit is evaluated on registered counts, so DONE follows the final sample by a cycle.
  always_comb begin
    limit_hit = (sample_limit != '0);
    for (int k = 0; k < NUM_CH; k++) begin
      if (count[k] != sample_limit) limit_hit = 1'b0;
    end
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en       <= 1'b0;
      divisor      <= 32'd1;
      sample_limit <= '0;
      ch_sel       <= '0;
    end else if (csr_write) begin
      case (csr_addr)
        ADDR_CTRL:    irq_en       <= csr_writedata[CTRL_IRQ_EN];
        ADDR_DIVISOR: divisor      <= csr_writedata;
        ADDR_LIMIT:   sample_limit <= csr_writedata;
        ADDR_CH_SEL:  ch_sel       <= csr_writedata;
        default: ;
      endcase
    end
  end

  // ---------------- capture ----------------
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      cap[k] = (state == ST_RUN) && ch_valid[k] &&
               ((sample_limit == '0) || (count[k] < sample_limit));
      pop[k] = rd_data_lo && (sel_ch == CW'(k));
    end
  end

  assign fifo_flush = run_entry || soft_reset;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf <= '0;
      for (int k = 0; k < NUM_CH; k++) count[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (run_entry) begin
          count[k] <= '0;
          ovf[k]   <= 1'b0;
        end else if (cap[k]) begin
          if (count[k] != '1) count[k] <= count[k] + 32'd1;
          // A dropped sample still counts towards the limit.
          if (fifo_full[k] && !pop[k]) ovf[k] <= 1'b1;
        end
      end
    end
  end

`ifdef ACQ_TIMESTAMP_EN
  logic [TS_W-1:0] tstamp;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       tstamp <= '0;
    else if (run_entry) tstamp <= '0;
    else                tstamp <= tstamp + TS_W'(1);
  end
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
`ifdef ACQ_TIMESTAMP_EN
    assign fifo_in[g] = {tstamp, ch_data[g*DATA_W +: DATA_W]};
`else
    assign fifo_in[g] = ch_data[g*DATA_W +: DATA_W];
`endif
    acq_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst_n     (reset_n),
      .flush     (fifo_flush),
      .push      (cap[g]),
      .push_data (fifo_in[g]),
      .pop       (pop[g]),
      .pop_data  (fifo_out[g]),
      .level     (fifo_level[g]),
      .empty     (fifo_empty[g]),
      .full      (fifo_full[g])
    );
  end

  // ---------------- divider ----------------
  // The active divisor is only reloaded at a wrap so a period never gets cut short.
  assign div_term  = (div_act > 32'd1) ? (div_act - 32'd1) : '0;
  assign ce_strobe = (state == ST_RUN) && (div_cnt == div_term);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      div_act <= 32'd1;
    end else if (run_entry) begin
      div_cnt <= '0;
      div_act <= divisor;
    end else if (state == ST_RUN) begin
      if (div_cnt == div_term) begin
        div_cnt <= '0;
        div_act <= divisor;
      end else begin
        div_cnt <= div_cnt + 32'd1;
      end
    end
  end

  // ---------------- soft reset pulse ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      soft_reset <= 1'b0;
      sr_cnt     <= '0;
    end else if (sr_req) begin
      soft_reset <= 1'b1;
      sr_cnt     <= SRW'(RST_PULSE - 1);
    end else if (sr_cnt != '0) begin
      sr_cnt     <= sr_cnt - SRW'(1);
    end else begin
      soft_reset <= 1'b0;
    end
  end

  // ---------------- read path ----------------
  // The FIFO's registered pop_data doubles as the DATA_LO/DATA_HI/TSTAMP latch;
  // pop_ch remembers which channel it came from.
  assign pop_word = 64'(fifo_out[pop_ch][DATA_W-1:0]);

  always_comb begin
    status_w = '0;
    status_w[STAT_STATE_LSB +: 2]      = state;
    status_w[STAT_OVF_LSB   +: NUM_CH] = ovf;
    status_w[STAT_EMPTY_LSB +: NUM_CH] = fifo_empty;
    rd_mux = '0;
    case (csr_addr)
      ADDR_CTRL:    rd_mux[CTRL_IRQ_EN] = irq_en;
      ADDR_STATUS:  rd_mux = status_w;
      ADDR_DIVISOR: rd_mux = divisor;
      ADDR_LIMIT:   rd_mux = sample_limit;
      ADDR_CH_SEL:  rd_mux = ch_sel;
      ADDR_LEVEL:   rd_mux = 32'(fifo_level[sel_ch]);
      ADDR_DATA_HI: rd_mux = pop_word[63:32];
`ifdef ACQ_TIMESTAMP_EN
      ADDR_TSTAMP:  rd_mux = fifo_out[pop_ch][DATA_W +: TS_W];
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fifo_rd_q <= 1'b0;
      rd_q      <= '0;
      pop_ch    <= '0;
    end else if (csr_read) begin
      fifo_rd_q <= rd_data_lo;
      rd_q      <= rd_mux;
      if (rd_data_lo) pop_ch <= sel_ch;
    end
  end

  // Both mux inputs are flops, so read data is stable for the whole cycle after the read.
  assign csr_readdata = fifo_rd_q ? pop_word[31:0] : rd_q;

endmodule

// File: tb/tb_acq_capture_hub.sv
module tb_acq_capture_hub;
  import acq_capture_pkg::*;

  localparam int NCH = 2;
  localparam int DW  = 64;
  localparam int DEP = 4;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [NCH*DW-1:0] ch_data = '0;
  logic [NCH-1:0]    ch_valid = '0;
  logic              calc_done = 1'b0;
  logic              enable, ce_strobe, soft_reset, irq;
  logic [3:0]        csr_addr = '0;
  logic              csr_write = 1'b0;
  logic [31:0]       csr_writedata = '0;
  logic              csr_read = 1'b0;
  logic [31:0]       csr_readdata;

  int checks = 0;
  int errors = 0;

  // Scoreboard: expected FIFO contents per channel plus a small capture model.
  logic [63:0] sb0[$];
  logic [63:0] sb1[$];
  int          mdl_cnt [NCH];
  int          mdl_lvl [NCH];
  logic [1:0]  mdl_ovf;
  int          mdl_limit;

  acq_capture_hub #(
    .NUM_CH(NCH), .DATA_W(DW), .DEPTH(DEP), .RST_PULSE(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ch_data(ch_data), .ch_valid(ch_valid),
    .calc_done(calc_done), .enable(enable), .ce_strobe(ce_strobe),
    .soft_reset(soft_reset), .irq(irq), .csr_addr(csr_addr),
    .csr_write(csr_write), .csr_writedata(csr_writedata),
    .csr_read(csr_read), .csr_readdata(csr_readdata)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic csr_wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    csr_addr = a; csr_writedata = d; csr_write = 1'b1;
    @(negedge clk);
    csr_write = 1'b0;
  endtask

  task automatic csr_rd(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    csr_addr = a; csr_read = 1'b1;
    @(negedge clk);
    csr_read = 1'b0;
    d = csr_readdata;
  endtask

  task automatic mdl_start();
    sb0.delete(); sb1.delete();
    for (int k = 0; k < NCH; k++) begin mdl_cnt[k] = 0; mdl_lvl[k] = 0; end
    mdl_ovf = '0;
  endtask

  task automatic sb_push(input int ch, input logic [63:0] v);
    if (ch == 0) sb0.push_back(v); else sb1.push_back(v);
  endtask

  task automatic sb_pop(input int ch, output logic [63:0] v);
    v = '0;
    if (ch == 0) begin if (sb0.size() > 0) v = sb0.pop_front(); end
    else begin if (sb1.size() > 0) v = sb1.pop_front(); end
    if (mdl_lvl[ch] > 0) mdl_lvl[ch]--;
  endtask

  // One valid cycle followed by one idle cycle; model decides push/drop.
  task automatic drive(input logic [1:0] vld, input logic [63:0] d0, input logic [63:0] d1);
    @(negedge clk);
    ch_valid = vld; ch_data = {d1, d0};
    for (int k = 0; k < NCH; k++) begin
      if (vld[k] && (mdl_limit == 0 || mdl_cnt[k] < mdl_limit)) begin
        mdl_cnt[k]++;
        if (mdl_lvl[k] < DEP) begin
          mdl_lvl[k]++;
          sb_push(k, (k == 0) ? d0 : d1);
        end else begin
          mdl_ovf[k] = 1'b1;
        end
      end
    end
    @(negedge clk);
    ch_valid = '0;
  endtask

  // Pops every expected entry of a channel and compares both halves.
  task automatic drain(input int ch);
    logic [31:0] r;
    logic [63:0] e;
    int n;
    csr_wr(ADDR_CH_SEL, 32'(ch));
    n = mdl_lvl[ch];
    for (int i = 0; i < n; i++) begin
      sb_pop(ch, e);
      csr_rd(ADDR_DATA_LO, r);
      checks++;
      if (r !== e[31:0]) begin errors++; $display("FAIL drain_lo ch%0d #%0d got=%h exp=%h", ch, i, r, e[31:0]); end
      csr_rd(ADDR_DATA_HI, r);
      checks++;
      if (r !== e[63:32]) begin errors++; $display("FAIL drain_hi ch%0d #%0d got=%h exp=%h", ch, i, r, e[63:32]); end
    end
  endtask

  task automatic test_reset();
    logic [31:0] r;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (enable !== 1'b0) begin errors++; $display("FAIL reset_enable got=%b exp=0", enable); end
    checks++; if (ce_strobe !== 1'b0) begin errors++; $display("FAIL reset_ce got=%b exp=0", ce_strobe); end
    checks++; if (soft_reset !== 1'b0) begin errors++; $display("FAIL reset_softrst got=%b exp=0", soft_reset); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq); end
    checks++; if (csr_readdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", csr_readdata); end
    csr_rd(ADDR_STATUS, r);
    checks++; if (r !== 32'h0003_0000) begin errors++; $display("FAIL reset_status got=%h exp=00030000", r); end
    csr_rd(ADDR_DIVISOR, r);
    checks++; if (r !== 32'd1) begin errors++; $display("FAIL reset_divisor got=%h exp=1", r); end
    csr_rd(ADDR_LIMIT, r);
    checks++; if (r !== 32'd0) begin errors++; $display("FAIL reset_limit got=%h exp=0", r); end
    csr_wr(4'd9, 32'hDEAD_BEEF);
    csr_rd(4'd9, r);
    checks++; if (r !== 32'd0) begin errors++; $display("FAIL unmapped got=%h exp=0", r); end
`ifndef ACQ_TIMESTAMP_EN
    csr_rd(ADDR_TSTAMP, r);
    checks++; if (r !== 32'd0) begin errors++; $display("FAIL tstamp_off got=%h exp=0", r); end
`endif
  endtask

  task automatic test_run_divider();
    logic [31:0] r;
    int n, first;
    csr_wr(ADDR_DIVISOR, 32'd4);
    csr_rd(ADDR_DIVISOR, r);
    checks++; if (r !== 32'd4) begin errors++; $display("FAIL divisor_rb got=%h exp=4", r); end
    csr_wr(ADDR_CTRL, 32'h8);
    csr_wr(ADDR_CTRL, 32'h9);
    mdl_start();
    checks++; if (enable !== 1'b1) begin errors++; $display("FAIL run_enable got=%b exp=1", enable); end
    n = 0; first = -1;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      if (ce_strobe === 1'b1) begin n++; if (first < 0) first = i; end
    end
    checks++; if (n != 4) begin errors++; $display("FAIL ce_count got=%0d exp=4", n); end
    checks++; if (first != 3) begin errors++; $display("FAIL ce_first got=%0d exp=3", first); end
    @(negedge clk); calc_done = 1'b1;
    @(negedge clk); calc_done = 1'b0;
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL done_irq got=%b exp=1", irq); end
    checks++; if (enable !== 1'b0) begin errors++; $display("FAIL done_enable got=%b exp=0", enable); end
    csr_rd(ADDR_STATUS, r);
    checks++; if (r[1:0] !== 2'd2) begin errors++; $display("FAIL done_state got=%0d exp=2", r[1:0]); end
  endtask

  task automatic test_sample_limit();
    logic [31:0] r;
    logic [63:0] e;
    csr_wr(ADDR_LIMIT, 32'd3);
    csr_wr(ADDR_CTRL, 32'h9);
    mdl_start(); mdl_limit = 3;
    for (int i = 0; i < 5; i++)
      drive(2'b11, 64'h1234_5678_9ABC_DEF0 + 64'(i), 64'hA5A5_0000_0000_1000 + 64'(i));
    csr_rd(ADDR_STATUS, r);
    checks++; if (r[1:0] !== 2'd2) begin errors++; $display("FAIL limit_state got=%0d exp=2", r[1:0]); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL limit_irq got=%b exp=1", irq); end
    for (int ch = 0; ch < NCH; ch++) begin
      csr_wr(ADDR_CH_SEL, 32'(ch));
      csr_rd(ADDR_LEVEL, r);
      checks++; if (r !== 32'(mdl_lvl[ch])) begin errors++; $display("FAIL limit_level ch%0d got=%0d exp=%0d", ch, r, mdl_lvl[ch]); end
    end
    drain(0);
    drain(1);
    csr_rd(ADDR_DATA_LO, r);
    sb_pop(1, e);
    checks++; if (r !== e[31:0]) begin errors++; $display("FAIL empty_pop got=%h exp=%h", r, e[31:0]); end
    csr_rd(ADDR_LEVEL, r);
    checks++; if (r !== 32'd0) begin errors++; $display("FAIL empty_level got=%0d exp=0", r); end
  endtask

  task automatic test_overflow();
    logic [31:0] r;
    csr_wr(ADDR_LIMIT, 32'd0);
    csr_wr(ADDR_CTRL, 32'h9);
    mdl_start(); mdl_limit = 0;
    for (int i = 0; i < 6; i++) drive(2'b10, 64'h0, 64'hC0DE_0000_0000_0000 + 64'(i));
    csr_wr(ADDR_CH_SEL, 32'd1);
    csr_rd(ADDR_LEVEL, r);
    checks++; if (r !== 32'(mdl_lvl[1])) begin errors++; $display("FAIL ovf_level got=%0d exp=%0d", r, mdl_lvl[1]); end
    csr_rd(ADDR_STATUS, r);
    checks++; if (r[15:8] !== {6'b0, mdl_ovf}) begin errors++; $display("FAIL ovf_bits got=%h exp=%h", r[15:8], {6'b0, mdl_ovf}); end
    checks++; if (r[23:16] !== 8'h01) begin errors++; $display("FAIL ovf_empty got=%h exp=01", r[23:16]); end
    csr_wr(ADDR_CH_SEL, 32'd7);
    csr_rd(ADDR_LEVEL, r);
    checks++; if (r !== 32'(mdl_lvl[0])) begin errors++; $display("FAIL chsel_oob got=%0d exp=%0d", r, mdl_lvl[0]); end
    csr_wr(ADDR_CH_SEL, 32'd1);
  endtask

  task automatic test_full_pushpop();
    logic [31:0] r;
    logic [63:0] e;
    logic [63:0] nv;
    nv = 64'hF00D_0000_0000_0042;
    @(negedge clk);
    csr_addr = ADDR_DATA_LO; csr_read = 1'b1;
    ch_valid = 2'b10; ch_data = {nv, 64'h0};
    @(negedge clk);
    csr_read = 1'b0; ch_valid = '0;
    r = csr_readdata;
    sb_pop(1, e);
    sb_push(1, nv); mdl_lvl[1]++;
    checks++; if (r !== e[31:0]) begin errors++; $display("FAIL pushpop_data got=%h exp=%h", r, e[31:0]); end
    csr_rd(ADDR_LEVEL, r);
    checks++; if (r !== 32'(mdl_lvl[1])) begin errors++; $display("FAIL pushpop_level got=%0d exp=%0d", r, mdl_lvl[1]); end
    drain(1);
  endtask

  task automatic test_soft_reset();
    logic [31:0] r;
    int n, first;
    drive(2'b01, 64'h1111_2222_3333_4444, 64'h0);
    drive(2'b01, 64'h5555_6666_7777_8888, 64'h0);
    csr_wr(ADDR_CH_SEL, 32'd0);
    csr_rd(ADDR_LEVEL, r);
    checks++; if (r !== 32'(mdl_lvl[0])) begin errors++; $display("FAIL presr_level got=%0d exp=%0d", r, mdl_lvl[0]); end
    csr_wr(ADDR_CTRL, 32'hC);
    n = 0; first = -1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      if (soft_reset === 1'b1) begin n++; if (first < 0) first = i; end
    end
    sb0.delete(); sb1.delete(); mdl_lvl[0] = 0; mdl_lvl[1] = 0;
    checks++; if (n != 4) begin errors++; $display("FAIL sr_len got=%0d exp=4", n); end
    checks++; if (first != 0) begin errors++; $display("FAIL sr_start got=%0d exp=0", first); end
    csr_rd(ADDR_LEVEL, r);
    checks++; if (r !== 32'd0) begin errors++; $display("FAIL sr_level got=%0d exp=0", r); end
    csr_rd(ADDR_STATUS, r);
    checks++; if (r[1:0] !== 2'd1) begin errors++; $display("FAIL sr_state got=%0d exp=1", r[1:0]); end
    csr_wr(ADDR_CTRL, 32'hA);
    checks++; if (enable !== 1'b0) begin errors++; $display("FAIL abort_enable got=%b exp=0", enable); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL abort_irq got=%b exp=0", irq); end
    csr_rd(ADDR_STATUS, r);
    checks++; if (r[1:0] !== 2'd0) begin errors++; $display("FAIL abort_state got=%0d exp=0", r[1:0]); end
    csr_wr(ADDR_CTRL, 32'hB);
    csr_rd(ADDR_STATUS, r);
    checks++; if (r[1:0] !== 2'd0) begin errors++; $display("FAIL abort_wins got=%0d exp=0", r[1:0]); end
  endtask

  task automatic test_async_reset();
    logic [31:0] r;
    csr_wr(ADDR_DIVISOR, 32'd4);
    csr_wr(ADDR_CTRL, 32'h1);
    checks++; if (enable !== 1'b1) begin errors++; $display("FAIL ar_pre_enable got=%b exp=1", enable); end
    csr_rd(ADDR_DIVISOR, r);
    checks++; if (r !== 32'd4) begin errors++; $display("FAIL ar_pre_rdata got=%h exp=4", r); end
    csr_wr(ADDR_CTRL, 32'h4);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({enable, ce_strobe, soft_reset, irq, csr_readdata} !== 36'h0) begin
      errors++;
      $display("FAIL async_outputs got=%b%b%b%b_%h exp=all zero", enable, ce_strobe, soft_reset, irq, csr_readdata);
    end
    @(negedge clk); reset_n = 1'b1;
    csr_rd(ADDR_STATUS, r);
    checks++; if (r !== 32'h0003_0000) begin errors++; $display("FAIL ar_status got=%h exp=00030000", r); end
    csr_rd(ADDR_DIVISOR, r);
    checks++; if (r !== 32'd1) begin errors++; $display("FAIL ar_divisor got=%h exp=1", r); end
  endtask

  initial begin
    mdl_limit = 0;
    mdl_start();
    test_reset();
    test_run_divider();
    test_sample_limit();
    test_overflow();
    test_full_pushpop();
    test_soft_reset();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/acq_capture_hub.md
# acq_capture_hub

Native-RTL successor to the Qsys-based run-control and result-FIFO path between the processing datapath and the NIOS/HPS. It sits between the datapath and the host.
- Captures NUM_CH parametrised-width result streams into per-channel FIFOs.
- Runs the calculation with an IDLE/RUN/DONE state machine and a divided clock-enable strobe instead of a derived clock.
- Generates the datapath soft-reset pulse and interrupt.
- Exposes everything through a 32-bit register slave with 1-cycle read latency.

## Interface
- NUM_CH, 2, number of result channels (1..8)
- DATA_W, 64, result width; 32 or 64 only
- DEPTH, 256, per-channel FIFO depth, power of two
- RST_PULSE, 4, soft_reset pulse length in cycles (>=1)
- clk  in  1  single system clock; all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- ch_data  in  NUM_CH*DATA_W  channel results, channel k at [k*DATA_W +: DATA_W]
- ch_valid  in  NUM_CH  per-channel sample strobe
- calc_done  in  1  level; datapath finished
- enable  out  1  high only in RUN
- ce_strobe  out  1  one-cycle clock-enable every DIVISOR cycles while in RUN
- soft_reset  out  1  active-high datapath/FIFO reset pulse
- irq  out  1  level; DONE and CTRL.irq_en
- csr_addr  in  4  word address
- csr_write  in  1  write strobe
- csr_writedata  in  32  write data
- csr_read  in  1  read strobe
- csr_readdata  out  32  registered read data

## Operation
- Registers:
  - 0 CTRL: W1 pulses bit0 start, bit1 abort, bit2 soft_rst; bit3 irq_en is R/W.
  - 1 STATUS (RO): [1:0] state (0 IDLE, 1 RUN, 2 DONE); [15:8] sticky overflow per channel; [23:16] FIFO empty per channel.
  - 2 DIVISOR, reset 1.
  - 3 SAMPLE_LIMIT, reset 0; 0 means unlimited.
  - 4 CH_SEL, reset 0; values >= NUM_CH are treated as 0.
  - 5 LEVEL (RO): entry count of the selected FIFO.
  - 6 DATA_LO: read pops the selected FIFO, returns bits [31:0] and latches bits [63:32].
  - 7 DATA_HI: returns the latched upper word; reads 0 when DATA_W=32.
  - 8 TSTAMP: see Configuration.
  - Unmapped addresses read 0 and ignore writes.
- FSM:
  - IDLE -start-> RUN. Entering RUN flushes all FIFOs, clears overflow bits, sample counters and the divider counter.
  - RUN -> DONE when calc_done is high, or when SAMPLE_LIMIT != 0 and every channel count == SAMPLE_LIMIT.
  - DONE -start-> RUN.
  - abort from any state -> IDLE; FIFOs are kept.
  - start while in RUN is ignored. Abort and start in the same write: abort wins.
- Capture: in RUN, ch_valid[k] with count_k < limit (or unlimited) increments count_k (32-bit, saturating) and pushes ch_data. If the FIFO is full, the sample is dropped and overflow[k] is set. ch_valid outside RUN is ignored.
- Pop on empty returns 0 and changes no state. Push and pop on the same FIFO in the same cycle are both performed, including when full; level is unchanged.
- soft_rst: soft_reset is high for exactly RST_PULSE cycles starting the cycle after the write and flushes all FIFOs. The FSM state is unaffected. A re-trigger restarts the count.
- Divider: the counter runs 0..DIVISOR-1 in RUN; ce_strobe is high on the terminal count. DIVISOR values 0 and 1 mean a strobe every cycle. A new DIVISOR is used from the next counter wrap.
- Reset values: enable, ce_strobe, soft_reset, irq, csr_readdata = 0; state IDLE; FIFOs empty.

## Timing
- A write at edge N takes effect at N+1; enable rises at N+1 after a start write.
- csr_read at cycle N gives csr_readdata valid at N+1; the pop commits at edge N.
- ch_valid at N is visible in LEVEL for a read issued at N+1.
- calc_done high at N gives state DONE and enable low at N+1. A sample valid at N is still captured.
- irq follows the state register combinationally-registered: high the same cycle DONE is entered if irq_en=1.

## Configuration
- ACQ_TIMESTAMP_EN defined:
  - Each FIFO entry also stores a 32-bit cycle counter, cleared on entering RUN.
  - A DATA_LO pop latches it, and TSTAMP (addr 8) returns it.
- ACQ_TIMESTAMP_EN undefined: no timestamp storage; TSTAMP reads 0.

## Structure
- Package acq_capture_pkg holds:
  - register address constants;
  - CTRL/STATUS bit positions;
  - the state enum (IDLE/RUN/DONE).
- Sub-module acq_fifo: single-clock FIFO with width and depth parameters, registered read, level output and synchronous flush. It is instantiated NUM_CH times.

## Test plan
- Run with DIVISOR=4: write start -> enable=1 next cycle; ce_strobe once every 4 cycles; calc_done -> STATUS=2, irq=1 with irq_en=1.
- SAMPLE_LIMIT=3, 5 valids on both channels -> LEVEL=3 per channel, auto DONE; DATA_LO/DATA_HI return the first sample's 64-bit value, e.g. 0x12345678_9ABCDEF0.
- DEPTH=4, 6 valids on channel 1 -> LEVEL=4, overflow bit 9 set, channel 0 bit clear; the last two samples are dropped.
- Full FIFO with simultaneous pop and push -> LEVEL stays 4; data order is preserved.
- soft_rst mid-RUN -> soft_reset high 4 cycles, LEVEL=0, state remains RUN; abort -> IDLE, enable=0.
- reset_n asserted mid-RUN -> all outputs 0 asynchronously; STATUS reads 0x00FF_0000 masked to NUM_CH empty bits after release.
